// File: rtl/komut_pkg.sv
// Shared types and constants for the instruction-decode stage: opcodes,
// instruction-class enum and the decoded-bundle record.
package komut_pkg;

  localparam logic [6:0] OP_R = 7'b0000001;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0000111;
  localparam logic [6:0] OP_B = 7'b0001111;

  // Widest legal XLEN; narrower builds leave the upper immediate bits at zero.
  localparam int IMM_W = 64;

  typedef enum logic [2:0] {
    TIP_R,
    TIP_I,
    TIP_U,
    TIP_B,
    TIP_GECERSIZ
  } komut_tipi_t;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [3:0]       aluop;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [IMM_W-1:0] imm;
    logic             hata;
  } cozum_t;

  function automatic komut_tipi_t tip_bul(input logic [6:0] op);
    case (op)
      OP_R:    return TIP_R;
      OP_I:    return TIP_I;
      OP_U:    return TIP_U;
      OP_B:    return TIP_B;
      default: return TIP_GECERSIZ;
    endcase
  endfunction

endpackage

// File: rtl/komut_cozucu_asama_yazmac_dosyasi.sv
// Integer register file: two combinational read ports, one write port,
// x0 hard-wired to zero, every register cleared by synchronous reset.
module yazmac_dosyasi
  import komut_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/komut_cozucu_asama.sv
// Pipelined decode stage: decodes komut at accept, reads operands with
// write-back bypass, and presents one registered bundle to the ALU.
module komut_cozucu_asama
  import komut_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int SIGN_EXT = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     komut,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [3:0]      aluop,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic            hata,
  output logic [15:0]     hata_sayac
);

  function automatic logic [XLEN-1:0] ext12(input logic [11:0] v);
    logic s;
    s = (SIGN_EXT != 0) && v[11];
    return {{(XLEN-12){s}}, v};
  endfunction

  function automatic logic [XLEN-1:0] ext13(input logic [12:0] v);
    logic s;
    s = (SIGN_EXT != 0) && v[12];
    return {{(XLEN-13){s}}, v};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  komut_tipi_t     tip;
  cozum_t          coz_p0;
  logic [XLEN-1:0] rs1_data_p0, rs2_data_p0;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [AW-1:0]   ra1, ra2;
  logic [4:0]      wb_idx;
  logic            accept;

  cozum_t          coz_p1;
  logic [XLEN-1:0] rs1_data_p1, rs2_data_p1;
  logic            vld_p1;
  logic            unused_imm;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // Stage p0: decode and operand read on the incoming komut
  always_comb begin
    tip           = tip_bul(komut[6:0]);
    coz_p0        = '0;
    coz_p0.opcode = komut[6:0];
    case (tip)
      TIP_R: begin
        coz_p0.aluop = {komut[30], komut[14:12]};
        coz_p0.rs1   = komut[19:15];
        coz_p0.rs2   = komut[24:20];
        coz_p0.rd    = komut[11:7];
      end
      TIP_I: begin
        coz_p0.aluop = {1'b0, komut[14:12]};
        coz_p0.rs1   = komut[19:15];
        coz_p0.rd    = komut[11:7];
        coz_p0.imm   = IMM_W'(ext12(komut[31:20]));
      end
      TIP_U: begin
        coz_p0.rd  = komut[11:7];
        coz_p0.imm = IMM_W'(komut[31:12]);
      end
      TIP_B: begin
        coz_p0.aluop = {1'b0, komut[14:12]};
        coz_p0.rs1   = komut[19:15];
        coz_p0.rs2   = komut[24:20];
        coz_p0.imm   = IMM_W'(ext13({komut[31:25], komut[11:7], 1'b0}));
      end
      default: coz_p0.hata = 1'b1;
    endcase
    // Unused index fields are zero, so checking all three covers only the used ones.
    if ({1'b0, coz_p0.rs1} >= 6'(NREG) || {1'b0, coz_p0.rs2} >= 6'(NREG) ||
        {1'b0, coz_p0.rd} >= 6'(NREG))
      coz_p0.hata = 1'b1;

    wb_idx      = 5'(wb_addr);
    rs1_data_p0 = '0;
    rs2_data_p0 = '0;
    if (!coz_p0.hata && coz_p0.rs1 != 5'd0)
      rs1_data_p0 = (wb_en && wb_idx == coz_p0.rs1) ? wb_data : rf_rd1;
    if (!coz_p0.hata && coz_p0.rs2 != 5'd0)
      rs2_data_p0 = (wb_en && wb_idx == coz_p0.rs2) ? wb_data : rf_rd2;
  end

  assign ra1 = coz_p0.rs1[AW-1:0];
  assign ra2 = coz_p0.rs2[AW-1:0];

  yazmac_dosyasi #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_yazmac (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (ra1),
    .raddr2 (ra2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // Stage p1: registered bundle, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      coz_p1      <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      hata_sayac  <= '0;
    end else if (accept) begin
      vld_p1      <= 1'b1;
      coz_p1      <= coz_p0;
      rs1_data_p1 <= rs1_data_p0;
      rs2_data_p1 <= rs2_data_p0;
      if (coz_p0.hata) hata_sayac <= sat_inc(hata_sayac);
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign opcode     = coz_p1.opcode;
  assign aluop      = coz_p1.aluop;
  assign rs1        = coz_p1.rs1;
  assign rs2        = coz_p1.rs2;
  assign rd         = coz_p1.rd;
  assign imm        = coz_p1.imm[XLEN-1:0];
  assign hata       = coz_p1.hata;
  assign rs1_data   = rs1_data_p1;
  assign rs2_data   = rs2_data_p1;
  assign unused_imm = ^coz_p1.imm;

endmodule

// File: doc/komut_cozucu_asama.md
Name: komut_cozucu_asama

Overview:
- Pipelined instruction-decode stage, successor to the combinational komut ayırıcı.
- Decodes the four custom formats: R=7'b0000001, I=7'b0000011, U=7'b0000111, B=7'b0001111.
- Owns the integer register file and supplies rs1_data/rs2_data with write-back bypass.
- Sits between fetch and ALU, with valid/ready handshakes on both sides; one registered output stage.

Parameters:
- XLEN, 32: data and immediate width; legal values are 32 and 64.
- NREG, 32: number of architectural registers; legal values are 16 and 32. AW = $clog2(NREG).
- SIGN_EXT, 1: 1 sign-extends I and B immediates from bit komut[31]; 0 zero-extends them (legacy behaviour).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  komut is valid
- in_ready  out  1  stage can accept komut
- komut  in  32  instruction word
- wb_en  in  1  register-file write enable
- wb_addr  in  AW  write-back register index
- wb_data  in  XLEN  write-back data
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts bundle
- opcode  out  7  komut[6:0]
- aluop  out  4  ALU operation
- rs1, rs2, rd  out  5 each  register indices
- rs1_data, rs2_data  out  XLEN  operand values
- imm  out  XLEN  immediate
- hata  out  1  illegal instruction flag for the current bundle
- hata_sayac  out  16  saturating count of illegal instructions accepted

Behaviour:
Clock and reset:
- One clock, clk. reset is synchronous and active-high.
- On reset: out_valid=0; opcode, aluop, rs1, rs2, rd, rs1_data, rs2_data, imm all 0; hata=0; hata_sayac=0; all NREG registers cleared to 0.
- Reset has priority over accept and write-back in the same cycle. An in-flight bundle is dropped.

Handshake:
- in_ready = !out_valid || out_ready (combinational). Accept when in_valid && in_ready.
- Latency is 1 cycle: an accept at edge N presents the bundle with out_valid=1 after edge N.
- If there is no accept while out_ready=1, out_valid goes to 0 at the next edge.
- While out_valid && !out_ready, every output holds stable. Operand data is a snapshot and is not refreshed by later write-backs.

Decode, computed on komut at accept:
- R: aluop={komut[30],komut[14:12]}; rs1=komut[19:15]; rs2=komut[24:20]; rd=komut[11:7]; imm=0.
- I: aluop={0,komut[14:12]}; rs1=komut[19:15]; rs2=0; rd=komut[11:7]; imm=ext(komut[31:20]).
- U: aluop=0; rs1=0; rs2=0; rd=komut[11:7]; imm=zero-extend(komut[31:12]), regardless of SIGN_EXT.
- B: aluop={0,komut[14:12]}; rs1=komut[19:15]; rs2=komut[24:20]; rd=0; imm=ext({komut[31:25],komut[11:7],1'b0}).
- ext() means sign-extend if SIGN_EXT=1, otherwise zero-extend.

Illegal instructions (hata=1):
- Any other opcode. For these, aluop, rs1, rs2, rd and imm are 0, and both data outputs are 0.
- Any used register index (rs1, rs2 or rd) >= NREG, possible only when NREG=16. The fields are still output, and data is 0.
- An illegal instruction still produces out_valid=1.
- hata_sayac increments once per accepted illegal instruction and saturates at 16'hFFFF.

Register file:
- Write happens on wb_en && wb_addr!=0. Register x0 always reads 0.
- Operand read at accept: if wb_en && wb_addr==rsX && rsX!=0 in the same cycle, rsX_data = wb_data (bypass). Otherwise the stored value is used.
- Unused operands (rs=0) read 0.

Decomposition:
- Shared package komut_pkg holds:
  - opcode constants OP_R, OP_I, OP_U, OP_B;
  - enum komut_tipi_t {TIP_R, TIP_I, TIP_U, TIP_B, TIP_GECERSIZ};
  - packed struct cozum_t {opcode, aluop, rs1, rs2, rd, imm, hata}.
- One sub-module, yazmac_dosyasi: the NREG x XLEN register file with two read ports, one write port, the x0 rule and synchronous reset.
- Decode logic and the output register stay in the top module.

Test Plan:
- Reset, then write x1=5 and x2=7, then komut=32'h40208181 (R) -> after 1 cycle: aluop=4'b1000, rs1=1, rs2=2, rd=3, rs1_data=5, rs2_data=7, imm=0, hata=0.
- komut=32'hFFF0A283 (I, rd=5, rs1=1) -> imm=32'hFFFFFFFF when SIGN_EXT=1; imm=32'h00000FFF when SIGN_EXT=0; aluop=4'b0010.
- Same cycle: accept R komut reading x2 while wb_en=1, wb_addr=2, wb_data=32'hDEADBEEF -> rs2_data=32'hDEADBEEF. Also wb_addr=0 with data 9 -> x0 still reads 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no accept. Release -> accept the next komut within 1 cycle, with no loss or duplicate.
- komut=32'h0000007F -> hata=1, all fields 0, out_valid=1, hata_sayac=1. Preload the counter to 16'hFFFF via repeated illegal instructions -> the counter stays at 16'hFFFF.
- NREG=16: R komut with rs1=17 -> hata=1. Assert reset while out_valid=1 -> out_valid=0 next cycle, and x1 reads 0 afterwards.
